fp_to_int_seq: RTL and testbench
================================

// Module: fp_to_int_seq
// PURPOSE
//  Multi-cycle IEEE-754 float -> signed integer converter; reverse direction of fpaddsub's pack path (unpack, align, round).
//  Takes one FP word via valid/ready, aligns significand 1 bit/cycle, rounds, returns W-bit two's-complement integer + flags.
//  Sits beside fpaddsub in the FP datapath; same LOG_BIT/EXP_BIT parameterisation (W = 2**LOG_BIT).
// PARAMETERS
//  LOG_BIT  6   log2 of word width W (FP operand and integer result both W bits)
//  EXP_BIT  11  exponent field width; MAN_BIT = W-1-EXP_BIT, BIAS = 2**(EXP_BIT-1)-1 (derived localparams)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  in_valid    in   1   in_fp/in_rm valid
//  in_ready    out  1   converter idle, can accept
//  in_fp       in   W   IEEE operand {sign, exp, man}
//  in_rm       in   1   rounding: 0 = toward zero, 1 = nearest-even
//  out_valid   out  1   result valid
//  out_ready   in   1   consumer accepts result
//  out_int     out  W   signed integer result
//  out_invalid out  1   NaN, inf or out-of-range input (result saturated)
//  out_inexact out  1   nonzero fraction discarded (0 when out_invalid)
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0 while rst high, 1 on first cycle after; out_valid=0, out_int=0, flags=0.
//  rst mid-operation aborts conversion, no result emitted. Reset has priority over every handshake.
//  FSM IDLE -> ALIGN -> ROUND -> DONE -> IDLE; in_ready = (state==IDLE); out_valid = (state==DONE).
//  IDLE: on in_valid&&in_ready latch sign, e = exp-BIAS (exp==0: e=1-BIAS, hidden=0), sig = {hidden,man}, rm.
//   Classify at accept: exp all-ones -> special; e >= W-1 -> overflow, except sign=1,e==W-1,man==0 -> exact -2**(W-1).
//   Special/overflow/exact-min go straight to DONE (out_valid 1 cycle after accept).
//   Else N = MAN_BIT-e right shifts (clamped to MAN_BIT+2) or e-MAN_BIT left shifts; N==0 -> ROUND directly.
//  ALIGN: one bit per cycle; right shifts feed guard, OR guard into sticky; stays exactly N cycles.
//  ROUND: rm=1 increment when guard && (sticky || lsb); magnitude >= 2**(W-1) after rounding -> saturate (invalid)
//   unless negative and exactly 2**(W-1); negate if sign; inexact = guard|sticky. Load outputs, -> DONE.
//  Latency accept->out_valid: N+2 cycles normal path; 1 cycle special path. No overlap: one conversion in flight.
//  DONE: out_int/flags held stable until out_ready; on out_valid&&out_ready -> IDLE (in_ready=1 next cycle).
//  in_valid while busy ignored (not latched); in_fp may change freely outside accept cycle.
//  Saturation: NaN -> 2**(W-1)-1; +inf/+overflow -> 2**(W-1)-1; -inf/-overflow -> -2**(W-1); all set out_invalid.
//  Zero and denormals: normal path, result 0 (±0 both -> 0); inexact=1 iff man!=0.
// STRUCTURE
//  fp_pkg (shared with fpaddsub): field-width/bias functions of (LOG_BIT,EXP_BIT), fp class enum
//   {ZERO,DENORM,NORMAL,INF,NAN}, rounding-mode constants RM_RTZ=0/RM_RNE=1, state enum for this FSM.
//  Sub-module fp_unpack: combinational split + classify (sign, biased/unbiased exp, significand, class); reusable by fpaddsub.
// TESTING (LOG_BIT=6, EXP_BIT=11)
//  2.5 (0x4004000000000000), rm=1 -> out_int=2, inexact=1, out_valid exactly 53 cycles after accept; rm=0 -> 2.
//  -3.5 (0xC00C000000000000), rm=1 -> 0xFFFFFFFFFFFFFFFC, inexact=1; 2**62 (0x43D0000000000000) -> 0x4000000000000000, no flags, 12-cycle latency.
//  +inf / NaN 0x7FF8000000000000 -> 0x7FFFFFFFFFFFFFFF, invalid=1, 1-cycle latency; -inf -> 0x8000000000000000, invalid=1.
//  -2**63 (0xC3E0000000000000) -> 0x8000000000000000, no flags; +2**63 (0x43E0000000000000) -> 0x7FFFFFFFFFFFFFFF, invalid=1.
//  Denormal 0x000FFFFFFFFFFFFF, rm=1 -> 0, inexact=1; out_ready low 5 cycles in DONE -> out_int stable, in_ready=0, pulsed in_valid ignored.
//  rst high 1 cycle mid-ALIGN -> out_valid never rises for that op, in_ready=1 cycle after rst falls, next op 1.0 -> 1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: field-width helpers, operand classes,
// rounding-mode codes and the float-to-int converter state encoding.
package fp_pkg;

   function automatic int unsigned fp_width(input int unsigned log_bit);
      return 1 << log_bit;
   endfunction

   function automatic int unsigned fp_man_bit(input int unsigned log_bit,
                                              input int unsigned exp_bit);
      return fp_width(log_bit) - 1 - exp_bit;
   endfunction

   function automatic int unsigned fp_bias(input int unsigned exp_bit);
      return (1 << (exp_bit - 1)) - 1;
   endfunction

   typedef enum logic [2:0] {
      FP_ZERO,
      FP_DENORM,
      FP_NORMAL,
      FP_INF,
      FP_NAN
   } fp_class_e;

   localparam logic RM_RTZ = 1'b0;
   localparam logic RM_RNE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ROUND,
      ST_DONE
   } f2i_state_e;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 field split and classification; e_c is the unbiased
// exponent in two's complement, sig_c carries the hidden bit on top.
module fp_unpack
   import fp_pkg::*;
#(
   parameter int unsigned LOG_BIT = 6,
   parameter int unsigned EXP_BIT = 11
) (
   input  logic [fp_width(LOG_BIT)-1:0]          fp,
   output logic                                  sign_c,
   output logic [EXP_BIT+1:0]                    e_c,
   output logic [fp_man_bit(LOG_BIT,EXP_BIT):0]  sig_c,
   output fp_class_e                             cls_c
);

   localparam int unsigned W       = fp_width(LOG_BIT);
   localparam int unsigned MAN_BIT = fp_man_bit(LOG_BIT, EXP_BIT);
   localparam int unsigned BIAS    = fp_bias(EXP_BIT);
   localparam int unsigned E_W     = EXP_BIT + 2;

   logic [EXP_BIT-1:0] exp_f;
   logic [MAN_BIT-1:0] man_f;
   logic               exp_zero;
   logic               exp_ones;
   logic               man_zero;

   always_comb begin
      exp_f    = fp[W-2 -: EXP_BIT];
      man_f    = fp[MAN_BIT-1:0];
      exp_zero = (exp_f == '0);
      exp_ones = (exp_f == '1);
      man_zero = (man_f == '0);
      sign_c   = fp[W-1];
      sig_c    = {!exp_zero, man_f};
      // Denormals share the smallest normal exponent, without the hidden bit.
      e_c      = exp_zero ? (E_W'(1) - E_W'(BIAS)) : (E_W'(exp_f) - E_W'(BIAS));
      if (exp_ones)       cls_c = man_zero ? FP_INF  : FP_NAN;
      else if (exp_zero)  cls_c = man_zero ? FP_ZERO : FP_DENORM;
      else                cls_c = FP_NORMAL;
   end

endmodule

// File: rtl/fp_to_int_seq.sv
// Multi-cycle float -> signed integer converter: unpack at accept, align the
// significand one bit per cycle, round (RTZ or RNE), saturate out-of-range.
module fp_to_int_seq
   import fp_pkg::*;
#(
   parameter int unsigned LOG_BIT = 6,
   parameter int unsigned EXP_BIT = 11
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [fp_width(LOG_BIT)-1:0]  in_fp,
   input  logic                          in_rm,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [fp_width(LOG_BIT)-1:0]  out_int,
   output logic                          out_invalid,
   output logic                          out_inexact
);

   localparam int unsigned W       = fp_width(LOG_BIT);
   localparam int unsigned MAN_BIT = fp_man_bit(LOG_BIT, EXP_BIT);
   localparam int unsigned E_W     = EXP_BIT + 2;
   localparam int unsigned CNT_W   = LOG_BIT + 1;

   localparam logic signed [E_W-1:0] E_WM1   = E_W'(W - 1);
   localparam logic signed [E_W-1:0] E_MAN   = E_W'(MAN_BIT);
   localparam logic signed [E_W-1:0] E_CLAMP = E_W'(MAN_BIT + 2);
   localparam logic [W-1:0]          INT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]          INT_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic [W:0]            MIN_MAG = {2'b01, {(W-1){1'b0}}};

   logic              up_sign_c;
   logic [E_W-1:0]    up_e_c;
   logic [MAN_BIT:0]  up_sig_c;
   fp_class_e         up_cls_c;

   fp_unpack #(.LOG_BIT(LOG_BIT), .EXP_BIT(EXP_BIT)) u_unpack (
      .fp     (in_fp),
      .sign_c (up_sign_c),
      .e_c    (up_e_c),
      .sig_c  (up_sig_c),
      .cls_c  (up_cls_c)
   );

   f2i_state_e        state_q, state_d;
   logic [W-1:0]      mag_q, mag_d;
   logic              guard_q, guard_d;
   logic              sticky_q, sticky_d;
   logic              sign_q, sign_d;
   logic              rm_q, rm_d;
   logic              left_q, left_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [W-1:0]      out_int_q, out_int_d;
   logic              out_invalid_q, out_invalid_d;
   logic              out_inexact_q, out_inexact_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;

   logic signed [E_W-1:0] e_s;
   logic signed [E_W-1:0] diff_s;
   logic [CNT_W-1:0]      shift_n;
   logic                  exact_min;
   logic                  overflow;
   logic                  special;
   logic                  inc;
   logic [W:0]            rnd;
   logic [W-1:0]          mag_r;

   // Next-state, datapath and output-register logic.
   always_comb begin
      state_d       = state_q;
      mag_d         = mag_q;
      guard_d       = guard_q;
      sticky_d      = sticky_q;
      sign_d        = sign_q;
      rm_d          = rm_q;
      left_d        = left_q;
      cnt_d         = cnt_q;
      out_int_d     = out_int_q;
      out_invalid_d = out_invalid_q;
      out_inexact_d = out_inexact_q;

      e_s       = $signed(up_e_c);
      diff_s    = E_MAN - e_s;
      exact_min = up_sign_c && (e_s == E_WM1) && (up_sig_c[MAN_BIT-1:0] == '0);
      overflow  = (e_s >= E_WM1) && !exact_min;
      special   = (up_cls_c == FP_INF) || (up_cls_c == FP_NAN);
      // Beyond MAN_BIT+2 right shifts every bit already sits in sticky.
      if (diff_s[E_W-1])          shift_n = CNT_W'(-diff_s);
      else if (diff_s > E_CLAMP)  shift_n = CNT_W'(MAN_BIT + 2);
      else                        shift_n = CNT_W'(diff_s);

      inc   = (rm_q == RM_RNE) && guard_q && (sticky_q || mag_q[0]);
      rnd   = {1'b0, mag_q} + (W+1)'(inc);
      mag_r = rnd[W-1:0];

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               sign_d   = up_sign_c;
               rm_d     = in_rm;
               mag_d    = W'(up_sig_c);
               guard_d  = 1'b0;
               sticky_d = 1'b0;
               left_d   = diff_s[E_W-1];
               cnt_d    = shift_n;
               if (special || overflow) begin
                  out_int_d     = ((up_cls_c == FP_NAN) || !up_sign_c) ? INT_MAX : INT_MIN;
                  out_invalid_d = 1'b1;
                  out_inexact_d = 1'b0;
                  state_d       = ST_DONE;
               end else if (exact_min) begin
                  out_int_d     = INT_MIN;
                  out_invalid_d = 1'b0;
                  out_inexact_d = 1'b0;
                  state_d       = ST_DONE;
               end else begin
                  state_d = (shift_n == '0) ? ST_ROUND : ST_ALIGN;
               end
            end
         end
         ST_ALIGN: begin
            if (left_q) begin
               mag_d = {mag_q[W-2:0], 1'b0};
            end else begin
               mag_d    = {1'b0, mag_q[W-1:1]};
               guard_d  = mag_q[0];
               sticky_d = sticky_q || guard_q;
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_ROUND;
         end
         ST_ROUND: begin
            if (rnd[W] || rnd[W-1]) begin
               if (sign_q && (rnd == MIN_MAG)) begin
                  out_int_d     = INT_MIN;
                  out_invalid_d = 1'b0;
                  out_inexact_d = guard_q || sticky_q;
               end else begin
                  out_int_d     = sign_q ? INT_MIN : INT_MAX;
                  out_invalid_d = 1'b1;
                  out_inexact_d = 1'b0;
               end
            end else begin
               out_int_d     = sign_q ? (~mag_r + W'(1)) : mag_r;
               out_invalid_d = 1'b0;
               out_inexact_d = guard_q || sticky_q;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         mag_q         <= '0;
         guard_q       <= 1'b0;
         sticky_q      <= 1'b0;
         sign_q        <= 1'b0;
         rm_q          <= 1'b0;
         left_q        <= 1'b0;
         cnt_q         <= '0;
         out_int_q     <= '0;
         out_invalid_q <= 1'b0;
         out_inexact_q <= 1'b0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         mag_q         <= mag_d;
         guard_q       <= guard_d;
         sticky_q      <= sticky_d;
         sign_q        <= sign_d;
         rm_q          <= rm_d;
         left_q        <= left_d;
         cnt_q         <= cnt_d;
         out_int_q     <= out_int_d;
         out_invalid_q <= out_invalid_d;
         out_inexact_q <= out_inexact_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_int     = out_int_q;
   assign out_invalid = out_invalid_q;
   assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Randomized self-checking bench for fp_to_int_seq (binary64 -> int64) against
// an arithmetic reference model (integer part, remainder vs half, range check).
module tb_fp_to_int_seq;

   localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_fp = '0;
   logic        in_rm = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_int;
   logic        out_invalid;
   logic        out_inexact;

   int n_total = 0;
   int n_bad   = 0;

   fp_to_int_seq #(.LOG_BIT(6), .EXP_BIT(11)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_fp       (in_fp),
      .in_rm       (in_rm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_int     (out_int),
      .out_invalid (out_invalid),
      .out_inexact (out_inexact)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   // value = sig * 2**(e-52); round the integer part by comparing the
   // discarded remainder with one half.
   function automatic void model(input logic [63:0] fp, input logic rm,
                                 output logic [63:0] res, output logic inv,
                                 output logic inx, output int lat);
      logic         sgn;
      logic [10:0]  ex;
      logic [51:0]  man;
      int           e, k;
      logic [127:0] sig, ip, rem, half, mag, lim;
      logic         up;
      sgn = fp[63]; ex = fp[62:52]; man = fp[51:0];
      inv = 1'b0; inx = 1'b0; lat = 1; res = '0;
      lim = 128'd1 << 63;
      if (ex == 11'h7FF) begin
         inv = 1'b1;
         res = (man != 0 || !sgn) ? MAX64 : MIN64;
         return;
      end
      e   = (ex == 0) ? -1022 : int'(ex) - 1023;
      sig = {75'b0, (ex != 0), man};
      if (e >= 63) begin
         if (sgn && e == 63 && man == 0) res = MIN64;
         else begin inv = 1'b1; res = sgn ? MIN64 : MAX64; end
         return;
      end
      if (e >= 52) begin
         mag = sig << (e - 52);
         lat = e - 52 + 2;
      end else begin
         k   = 52 - e;
         lat = ((k > 54) ? 54 : k) + 2;
         if (k >= 100) begin
            ip = '0; rem = sig; half = 128'd1 << 99;
         end else begin
            ip = sig >> k; rem = sig - (ip << k); half = 128'd1 << (k - 1);
         end
         up  = rm && ((rem > half) || (rem == half && ip[0]));
         inx = (rem != 0);
         mag = ip + 128'(up);
      end
      if (mag >= lim) begin
         if (sgn && mag == lim) res = MIN64;
         else begin inv = 1'b1; inx = 1'b0; res = sgn ? MIN64 : MAX64; end
      end else begin
         res = sgn ? (~mag[63:0] + 64'd1) : mag[63:0];
      end
   endfunction

   task automatic run_op(input logic [63:0] fp, input logic rm, input int stall, input string tag);
      logic [63:0] e_res, held;
      logic        e_inv, e_inx;
      int          e_lat, lat, waitc;
      model(fp, rm, e_res, e_inv, e_inx, e_lat);
      waitc = 0;
      while (!in_ready && waitc < 100) begin @(negedge clk); waitc++; end
      if (!in_ready) begin check({tag, " in_ready"}, 64'(in_ready), 64'd1); return; end
      in_fp = fp; in_rm = rm; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; in_fp = {$urandom, $urandom}; in_rm = 1'($urandom);
      lat = 1;
      while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
      check({tag, " latency"}, 64'(lat), 64'(e_lat));
      if (!out_valid) return;
      check({tag, " int"}, out_int, e_res);
      check({tag, " flags"}, {62'b0, out_invalid, out_inexact}, {62'b0, e_inv, e_inx});
      held = out_int;
      for (int i = 0; i < stall; i++) begin
         in_valid = (i == 1);
         in_fp    = {$urandom, $urandom};
         @(negedge clk);
         check({tag, " hold int"}, out_int, held);
         check({tag, " hold hs"}, {62'b0, out_valid, in_ready}, 64'b10);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      check({tag, " release"}, {62'b0, out_valid, in_ready}, 64'b01);
   endtask

   function automatic logic [63:0] rand_fp();
      logic [63:0] r;
      logic [51:0] man, mask;
      logic [10:0] ex;
      int          e, k, sel;
      r   = {$urandom, $urandom};
      man = r[51:0];
      sel = $urandom_range(0, 9);
      case (sel)
         0: begin ex = 11'h7FF; if ($urandom_range(0, 1) == 0) man = '0; else man[0] = 1'b1; end
         1: begin ex = '0; if ($urandom_range(0, 2) == 0) man = '0; end
         2: begin ex = 11'(1023 + $urandom_range(60, 66)); if ($urandom_range(0, 1) == 0) man = '0; end
         3: begin
            e    = $urandom_range(0, 20);
            k    = 52 - e;
            mask = (52'd1 << k) - 52'd1;
            man  = (man & ~mask) | (52'd1 << (k - 1));
            ex   = 11'(1023 + e);
         end
         default: ex = 11'(1023 - 5 + $urandom_range(0, 70));
      endcase
      return {r[63], ex, man};
   endfunction

   initial begin
      int seen;
      // Reset state.
      repeat (2) @(negedge clk);
      check("reset hs", {62'b0, in_ready, out_valid}, 64'b00);
      check("reset int", out_int, 64'd0);
      check("reset flags", {62'b0, out_invalid, out_inexact}, 64'd0);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("post reset in_ready", 64'(in_ready), 64'd1);

      run_op(64'h4004_0000_0000_0000, 1'b1, 0, "2.5 rne");
      run_op(64'h4004_0000_0000_0000, 1'b0, 1, "2.5 rtz");
      run_op(64'hC00C_0000_0000_0000, 1'b1, 0, "-3.5 rne");
      run_op(64'h43D0_0000_0000_0000, 1'b0, 0, "2^62");
      run_op(64'h7FF0_0000_0000_0000, 1'b1, 0, "+inf");
      run_op(64'h7FF8_0000_0000_0000, 1'b0, 0, "nan");
      run_op(64'hFFF0_0000_0000_0000, 1'b1, 0, "-inf");
      run_op(64'hC3E0_0000_0000_0000, 1'b1, 0, "-2^63");
      run_op(64'h43E0_0000_0000_0000, 1'b1, 0, "+2^63");
      run_op(64'h000F_FFFF_FFFF_FFFF, 1'b1, 5, "denorm stall");
      run_op(64'h8000_0000_0000_0000, 1'b1, 0, "-0");
      run_op(64'h4330_0000_0000_0000, 1'b1, 0, "2^52");

      // Abort mid-ALIGN with a one-cycle reset.
      in_fp = 64'h4004_0000_0000_0000; in_rm = 1'b1; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("abort in rst", {62'b0, in_ready, out_valid}, 64'b00);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("abort in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort no result", 64'(seen), 64'd0);
      run_op(64'h3FF0_0000_0000_0000, 1'b0, 0, "1.0 after abort");

      for (int n = 0; n < 150; n++) begin
         run_op(rand_fp(), 1'($urandom), $urandom_range(0, 3), $sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
